fetch_unit: RTL and testbench

// - Front-end stage directly upstream of the core's IF register. Issues 8-byte-aligned fetch requests to instruction memory.
// - Buffers each 64-bit response as two 32-bit instruction slots in a FIFO.
// - Presents up to DISPATCH_WIDTH (=2) instructions per cycle on instruction[0:1]/instr_valid[0:1].
// - Supports a redirect (flush) that discards buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the IF register.
//   Issues 8-byte-aligned requests to instruction memory, splits each 64-bit
//   response into two 32-bit slots in a FIFO, and presents the two oldest
//   slots per cycle. A flush retargets fetch and discards buffered and
//   in-flight data.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush, flush_pc    redirect request and target (bits [1:0] ignored)
//   instruction[0:1]   FIFO head and head+1 (zero when not valid)
//   instr_valid[1:0]   slot valid flags; valid slots are consumed the same cycle
//   out_pc             PC of instruction[0]
//   imem_req/addr      fetch request and 8-byte-aligned address
//   imem_ready         memory accepts request this cycle
//   imem_rvalid/rdata  in-order response; [31:0] @addr, [63:32] @addr+4
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH     = 8,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] instruction [0:1],
    output logic [1:0]  instr_valid,
    output logic [31:0] out_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [QUEUE_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1, wr_ptr1;
    logic [CntW-1:0]   count_q, count_d, pop_cnt, push_cnt;
    logic [OutW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d;
    logic              skip_low_q, skip_low_d;
    logic [31:0]       credit_need;
    logic              accept, resp_keep, push_lo, push_hi;

    // Address bits [1:0] carry no information.
    logic unused_flush_pc;
    assign unused_flush_pc = ^flush_pc[1:0];

    // Credit check reserves two slots per in-flight request so a response
    // always fits; the request is also held off while reset is asserted.
    always_comb begin
        credit_need = 32'(count_q) + (32'(inflight_q) << 1) + 32'd2;
        imem_req    = !rst && (state_q == StRun) && !flush
                      && (32'(inflight_q) < MAX_OUTSTANDING)
                      && (credit_need <= QUEUE_DEPTH);
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
    end

    // Output view of the FIFO head; nothing is offered in a flush cycle.
    always_comb begin
        rd_ptr1        = rd_ptr_q + PtrW'(1);
        instr_valid[0] = !flush && (count_q != '0);
        instr_valid[1] = !flush && (count_q >= CntW'(2));
        instruction[0] = instr_valid[0] ? mem_q[rd_ptr_q] : '0;
        instruction[1] = instr_valid[1] ? mem_q[rd_ptr1] : '0;
        out_pc         = out_pc_q;
        pop_cnt        = CntW'(instr_valid[0]) + CntW'(instr_valid[1]);
    end

    // Responses during a flush or while draining stale requests are dropped.
    always_comb begin
        wr_ptr1   = wr_ptr_q + PtrW'(1);
        resp_keep = imem_rvalid && !flush && (drop_q == '0);
        push_hi   = resp_keep;
        push_lo   = resp_keep && !skip_low_q;
        push_cnt  = push_lo ? CntW'(2) : (push_hi ? CntW'(1) : '0);
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q + PtrW'(pop_cnt);
        wr_ptr_d   = wr_ptr_q + PtrW'(push_cnt);
        count_d    = count_q - pop_cnt + push_cnt;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        skip_low_d = skip_low_q;
        out_pc_d   = out_pc_q + (32'(pop_cnt) << 2);

        if (accept && !imem_rvalid) begin
            inflight_d = inflight_q + OutW'(1);
        end else if (!accept && imem_rvalid) begin
            inflight_d = inflight_q - OutW'(1);
        end

        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - OutW'(1);
        end
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd8;
        end
        if (resp_keep) begin
            skip_low_d = 1'b0;
        end

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // No accept can happen in a flush cycle, so this is the
            // in-flight count left once this cycle's response retires.
            drop_d     = imem_rvalid ? inflight_q - OutW'(1) : inflight_q;
            fetch_pc_d = {flush_pc[31:3], 3'b000};
            skip_low_d = flush_pc[2];
            out_pc_d   = {flush_pc[31:2], 2'b00};
            state_d    = (drop_d != '0) ? StDrain : StRun;
        end else if ((state_q == StDrain) && (drop_d == '0)) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            skip_low_q <= 1'b0;
            out_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            skip_low_q <= skip_low_d;
            out_pc_q   <= out_pc_d;
        end
    end

    // Storage needs no reset: slots are only visible once written.
    always_ff @(posedge clk) begin
        if (push_lo) begin
            mem_q[wr_ptr_q] <= imem_rdata[31:0];
            mem_q[wr_ptr1]  <= imem_rdata[63:32];
        end else if (push_hi) begin
            mem_q[wr_ptr_q] <= imem_rdata[63:32];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model answers accepted requests in order,
// and a stream-level reference model predicts every output each cycle.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] instruction [0:1];
    logic [1:0]  instr_valid;
    logic [31:0] out_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;

    fetch_unit #(
        .QUEUE_DEPTH    (DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC       (RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .out_pc     (out_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    req_t        mq[$];     // accepted, unanswered requests (oldest first)
    logic [31:0] fq[$];     // PCs of instructions waiting to be dispatched
    logic [31:0] m_fetch;   // next fetch address
    logic [31:0] m_push;    // next PC the instruction stream expects
    logic [31:0] m_out;     // PC of the next instruction to dispatch
    int unsigned total;
    int unsigned passed;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        fq.delete();
        m_fetch = RPC;
        m_push  = RPC;
        m_out   = RPC;
    endtask

    // One clock cycle: drive inputs, check all outputs, then advance the model.
    task automatic step(input bit fl, input logic [31:0] fpc, input bit rdy, input bit rsp_en);
        bit   rsp;
        bit   exp_req;
        bit   accept;
        bit   stale_any;
        int   n;
        req_t e;
        @(negedge clk);
        rsp         = rsp_en && (mq.size() > 0);
        flush       = fl;
        flush_pc    = fpc;
        imem_ready  = rdy;
        imem_rvalid = rsp;
        imem_rdata  = rsp ? {word_at(mq[0].addr + 32'd4), word_at(mq[0].addr)}
                          : {$urandom, $urandom};
        #1;
        stale_any = 0;
        foreach (mq[i]) if (mq[i].stale) stale_any = 1;
        exp_req = !fl && !stale_any && (mq.size() < MAXO)
                  && (fq.size() + 2 * mq.size() + 2 <= DEPTH);
        n = fl ? 0 : ((fq.size() >= 2) ? 2 : fq.size());
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_fetch);
        chk("instr_valid", 32'(instr_valid), (n == 2) ? 32'd3 : 32'(n));
        chk("instruction0", instruction[0], (n >= 1) ? word_at(fq[0]) : 32'd0);
        chk("instruction1", instruction[1], (n == 2) ? word_at(fq[1]) : 32'd0);
        chk("out_pc", out_pc, m_out);
        accept = exp_req && rdy;
        @(posedge clk);
        if (rsp) e = mq.pop_front();
        if (fl) begin
            foreach (mq[i]) mq[i].stale = 1;
            fq.delete();
            m_fetch = {fpc[31:3], 3'b000};
            m_push  = {fpc[31:2], 2'b00};
            m_out   = m_push;
        end else begin
            for (int i = 0; i < n; i++) begin
                void'(fq.pop_front());
                m_out += 32'd4;
            end
            if (rsp && !e.stale) begin
                // Keep only words that continue the expected PC stream.
                if (e.addr == m_push) begin
                    fq.push_back(e.addr);
                    m_push += 32'd4;
                end
                if (e.addr + 32'd4 == m_push) begin
                    fq.push_back(e.addr + 32'd4);
                    m_push += 32'd4;
                end
            end
        end
        if (accept) begin
            mq.push_back(req_t'{addr: m_fetch, stale: 1'b0});
            m_fetch += 32'd8;
        end
    endtask

    // Reset asserted between clock edges; outputs must respond at once.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr0", instruction[0], 32'd0);
        chk("rst_out_pc", out_pc, RPC);
        model_reset();
        flush       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RPC);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        flush       = 1'b0;
        flush_pc    = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        total       = 0;
        passed      = 0;
        model_reset();

        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr1", instruction[1], 32'd0);
        chk("reset_out_pc", out_pc, RPC);
        @(negedge clk);
        rst = 1'b0;

        // Continuous streaming with single-cycle memory latency.
        repeat (20) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Responses withheld: requests stop at the outstanding limit.
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0);
        // Redirect with two requests in flight, target in the upper half-word.
        step(1'b1, 32'h8000_0104, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Redirect coinciding with a response and memory ready.
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'h8000_0203, 1'b1, 1'b1);
        repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Odd slot counts from a half-word-start redirect with sparse responses.
        step(1'b1, 32'h8000_0304, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Fetch address wrap-around.
        step(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
        repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Reset in the middle of a stream.
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        async_reset();
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);

        // Randomized traffic with occasional redirects.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(31))
                                           : 32'h8000_0000 + ($urandom & 32'h0000_FFFF);
            step($urandom_range(11) == 0, tgt, $urandom_range(3) != 0,
                 $urandom_range(2) != 0);
        end
        async_reset();
        repeat (10) step(1'b0, 32'd0, $urandom_range(1) == 1, $urandom_range(1) == 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
